// File: rtl/sar_sequencer.sv
// Host-side sequencer for the 8-bit R2R SAR converter: paces conversions, averages
// 2^AVG_LOG2 captures and flags a stalled converter. Option macro: SAR_SEQ_AVG_ROUND_EN.
module sar_sequencer #(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear_err,
    input  logic       sar_valid,
    input  logic [7:0] sar_result,
    output logic       sar_go,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic [7:0] last_raw,
    output logic       busy,
    output logic       timeout_err
);

    localparam int DATA_W = 8;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
`ifdef SAR_SEQ_AVG_ROUND_EN
    localparam logic [ACC_W:0]   RND_HALF = (ACC_W + 1)'((1 << AVG_LOG2) >> 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        CONV,
        WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PER_W-1:0]   per_cnt;
    logic [TO_W-1:0]    tmo_cnt;
    logic               wait_met;
    logic               capture;
    logic               tmo_hit;
    logic               abort;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc_sum_p0;

    // Averaged word from a full accumulator; rounding adds half an LSB at one extra bit.
    function automatic logic [DATA_W-1:0] avg_word(input logic [ACC_W-1:0] acc_in);
`ifdef SAR_SEQ_AVG_ROUND_EN
        logic [ACC_W:0] shifted;
        shifted = ({1'b0, acc_in} + RND_HALF) >> AVG_LOG2;
        if (|shifted[ACC_W:DATA_W]) begin
            return {DATA_W{1'b1}};
        end
        return shifted[DATA_W-1:0];
`else
        return DATA_W'(acc_in >> AVG_LOG2);
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        abort     = 1'b0;
        sar_go    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = START;
                end
            end
            START: begin
                sar_go = 1'b1;
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                sar_go = 1'b1;
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (sar_valid) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end else if (tmo_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // wait_met guarantees go stays low for two cycles even after an overrun
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_met && per_cnt == '0) begin
                    state_nxt = START;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = sar_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt  <= '0;
            tmo_cnt  <= '0;
            wait_met <= 1'b0;
        end else begin
            wait_met <= (state == WAIT);
            if (state_nxt == START) begin
                per_cnt <= PER_LOAD;
                tmo_cnt <= TO_LOAD;
            end else begin
                if (per_cnt != '0) begin
                    per_cnt <= per_cnt - PER_W'(1);
                end
                if (tmo_cnt != '0) begin
                    tmo_cnt <= tmo_cnt - TO_W'(1);
                end
            end
        end
    end

    assign acc_sum_p0 = acc + ACC_W'(sar_result);

    // Capture stage: accumulate, and on the last sample emit the average next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            cnt         <= '0;
            avg_out     <= '0;
            avg_valid   <= 1'b0;
            last_raw    <= '0;
            timeout_err <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (abort) begin
                acc <= '0;
                cnt <= '0;
            end else if (capture) begin
                last_raw <= sar_result;
                if (cnt == CNT_LAST) begin
                    avg_out   <= avg_word(acc_sum_p0);
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum_p0;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer: two instances (averaging by 4, and single-sample),
// each driven by a behavioural converter that raises valid a set number of cycles after go.
module tb_sar_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_err;
    logic       enable_a;
    logic       enable_b;
    logic       go_a, go_b, busy_a, busy_b;
    logic       avg_valid_a, avg_valid_b, err_a, err_b;
    logic [7:0] avg_out_a, avg_out_b, last_raw_a, last_raw_b;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic [7:0] result_a = 8'h00;
    logic [7:0] result_b = 8'h00;
    logic [7:0] res_a, res_b;
    int         dly_a, dly_b;
    int         cnt_a = 0;
    int         cnt_b = 0;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

`ifdef SAR_SEQ_AVG_ROUND_EN
    localparam logic [7:0] EXP_MIX = 8'd12;
`else
    localparam logic [7:0] EXP_MIX = 8'd11;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_sequencer #(.SAMPLE_PERIOD(50), .AVG_LOG2(2), .TIMEOUT(40)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable_a),
        .clear_err  (clear_err),
        .sar_valid  (valid_a),
        .sar_result (result_a),
        .sar_go     (go_a),
        .avg_out    (avg_out_a),
        .avg_valid  (avg_valid_a),
        .last_raw   (last_raw_a),
        .busy       (busy_a),
        .timeout_err(err_a)
    );

    sar_sequencer #(.SAMPLE_PERIOD(50), .AVG_LOG2(0), .TIMEOUT(100)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable_b),
        .clear_err  (clear_err),
        .sar_valid  (valid_b),
        .sar_result (result_b),
        .sar_go     (go_b),
        .avg_out    (avg_out_b),
        .avg_valid  (avg_valid_b),
        .last_raw   (last_raw_b),
        .busy       (busy_b),
        .timeout_err(err_b)
    );

    // Converter models: valid for one cycle, dly cycles after go rises.
    always @(negedge clk) begin
        valid_a = 1'b0;
        if (!go_a) begin
            cnt_a = 0;
        end else begin
            cnt_a = cnt_a + 1;
            if (cnt_a == dly_a + 1) begin
                valid_a  = 1'b1;
                result_a = res_a;
            end
        end
    end

    always @(negedge clk) begin
        valid_b = 1'b0;
        if (!go_b) begin
            cnt_b = 0;
        end else begin
            cnt_b = cnt_b + 1;
            if (cnt_b == dly_b + 1) begin
                valid_b  = 1'b1;
                result_b = res_b;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_go_a(input logic lvl, output int n);
        n = 0;
        while (go_a !== lvl && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_go_b(input logic lvl, output int n);
        n = 0;
        while (go_b !== lvl && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic sample_a(input logic [7:0] v, input logic exp_avg, input string tag);
        int n;
        res_a = v;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_a && n < 150);
        check_eq({tag, "_seen"}, 32'(valid_a), 32'd1);
        check_eq({tag, "_raw"}, 32'(last_raw_a), 32'(v));
        check_eq({tag, "_avg_valid"}, 32'(avg_valid_a), 32'(exp_avg));
    endtask

    task automatic block_a(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                           input logic [7:0] v3, input logic [7:0] exp, input string tag);
        sample_a(v0, 1'b0, {tag, "_s0"});
        sample_a(v1, 1'b0, {tag, "_s1"});
        sample_a(v2, 1'b0, {tag, "_s2"});
        sample_a(v3, 1'b1, {tag, "_s3"});
        check_eq({tag, "_avg_out"}, 32'(avg_out_a), 32'(exp));
    endtask

    initial begin
        int n;
        int t0;
        reset     = 1'b1;
        clear_err = 1'b0;
        enable_a  = 1'b0;
        enable_b  = 1'b0;
        res_a     = 8'h00;
        res_b     = 8'h00;
        dly_a     = 20;
        dly_b     = 20;
        repeat (3) tick();
        check_eq("rst_go", 32'(go_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_avg_out", 32'(avg_out_a), 32'd0);
        check_eq("rst_avg_valid", 32'(avg_valid_a), 32'd0);
        check_eq("rst_last_raw", 32'(last_raw_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;

        // Single-sample instance: timing, period and overrun restart
        res_b    = 8'h5A;
        enable_b = 1'b1;
        wait_go_b(1'b1, n);
        check_eq("b_go_rise", 32'(go_b), 32'd1);
        t0 = cyc;
        wait_go_b(1'b0, n);
        check_eq("b_go_high_cycles", n, 32'd21);
        check_eq("b_last_raw", 32'(last_raw_b), 32'h5A);
        check_eq("b_avg_out", 32'(avg_out_b), 32'h5A);
        check_eq("b_avg_valid", 32'(avg_valid_b), 32'd1);
        tick();
        check_eq("b_avg_valid_drop", 32'(avg_valid_b), 32'd0);
        dly_b = 60;
        res_b = 8'h33;
        wait_go_b(1'b1, n);
        check_eq("b_period", cyc - t0, 32'd50);
        wait_go_b(1'b0, n);
        check_eq("b_overrun_high", n, 32'd61);
        check_eq("b_overrun_raw", 32'(last_raw_b), 32'h33);
        check_eq("b_overrun_avg", 32'(avg_out_b), 32'h33);
        wait_go_b(1'b1, n);
        check_eq("b_overrun_gap", n, 32'd2);
        check_eq("b_overrun_err", 32'(err_b), 32'd0);
        enable_b = 1'b0;

        // Averaging instance
        enable_a = 1'b1;
        block_a(8'd10, 8'd11, 8'd12, 8'd14, EXP_MIX, "avg_mix");
        tick();
        check_eq("avg_valid_drop", 32'(avg_valid_a), 32'd0);
        block_a(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, "avg_max");

        dly_a = 100000;
        wait_go_a(1'b1, n);
        check_eq("tmo_go_rise", 32'(go_a), 32'd1);
        wait_go_a(1'b0, n);
        check_eq("tmo_go_high_cycles", n, 32'd40);
        check_eq("tmo_err_set", 32'(err_a), 32'd1);
        dly_a = 20;
        block_a(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, "tmo_recover");
        check_eq("tmo_err_sticky", 32'(err_a), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_eq("tmo_err_clear", 32'(err_a), 32'd0);

        sample_a(8'h10, 1'b0, "abort_p0");
        sample_a(8'h20, 1'b0, "abort_p1");
        wait_go_a(1'b1, n);
        repeat (5) tick();
        check_eq("abort_pre_go", 32'(go_a), 32'd1);
        enable_a = 1'b0;
        tick();
        check_eq("abort_go", 32'(go_a), 32'd0);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_raw_hold", 32'(last_raw_a), 32'h20);
        check_eq("abort_avg_hold", 32'(avg_out_a), 32'h80);
        tick();
        enable_a = 1'b1;
        block_a(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, "post_abort");

        wait_go_a(1'b1, n);
        repeat (3) tick();
        check_eq("rstmid_pre_go", 32'(go_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid_go", 32'(go_a), 32'd0);
        check_eq("rstmid_busy", 32'(busy_a), 32'd0);
        check_eq("rstmid_avg_valid", 32'(avg_valid_a), 32'd0);
        check_eq("rstmid_avg_out", 32'(avg_out_a), 32'd0);
        check_eq("rstmid_last_raw", 32'(last_raw_a), 32'd0);
        check_eq("rstmid_err", 32'(err_a), 32'd0);
        enable_a = 1'b0;
        #10;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
- Host-side controller for the 8-bit R2R SAR converter. It is the other end of the converter's go/valid/result interface.
- Starts conversions at a fixed sample rate by driving go, and captures result when valid is seen.
- Averages 2^AVG_LOG2 samples and presents the averaged word with a one-cycle strobe to downstream logic (display, UART).
- Guards against a stalled converter with a conversion timeout.

Parameters:
- SAMPLE_PERIOD, 100000: clock cycles from one conversion start to the next (must be ≥ 4).
- AVG_LOG2, 2: log2 of the number of samples averaged per output (0..4).
- TIMEOUT, 200000: maximum cycles go may be held waiting for valid.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run sampling while high
- clear_err  in  1  clears timeout_err when high
- sar_valid  in  1  converter done indication (high one cycle per conversion)
- sar_result  in  8  converter result, valid while sar_valid high
- sar_go  out  1  converter go/run request
- avg_out  out  8  averaged result
- avg_valid  out  1  one-cycle strobe, avg_out updated
- last_raw  out  8  most recent captured raw result
- busy  out  1  high while sar_go high
- timeout_err  out  1  sticky converter-timeout flag

Behaviour:
- Reset (async, active-high):
  - Outputs: sar_go=0, avg_out=0, avg_valid=0, last_raw=0, busy=0, timeout_err=0.
  - Internal: state=IDLE, accumulator=0, sample count=0, period counter=0.
- IDLE: sar_go=0. When enable=1, go to START next cycle.
- START: sar_go=1 for exactly one cycle. Load period counter with SAMPLE_PERIOD-1, load timeout counter with TIMEOUT-1, then go to CONV.
- CONV: sar_go=1. Period and timeout counters decrement each cycle.
  - sar_valid=1: capture sar_result into last_raw, add it to the accumulator, increment count, deassert sar_go next cycle, go to WAIT.
  - Timeout counter reaches 0 with no valid: set timeout_err, deassert sar_go, discard the sample (accumulator and count unchanged), go to WAIT.
  - sar_valid and timeout expiry in the same cycle: valid wins and no error is flagged.
- WAIT: sar_go=0 for at least 2 cycles, so the converter returns to its wait state and clears its result. Period counter keeps decrementing.
  - Leave for START when the period counter is 0 and the minimum-low time is met.
  - If a conversion overran SAMPLE_PERIOD, the next start is exactly 2 cycles after sar_go falls.
- Averaging:
  - Accumulator width is 8+AVG_LOG2 bits and cannot overflow.
  - When the count reaches 2^AVG_LOG2 on a capture, in the following cycle:
    - avg_out = accumulator >> AVG_LOG2, truncated;
    - avg_valid=1 for one cycle;
    - accumulator and count clear to 0.
  - AVG_LOG2=0: every capture produces avg_out=raw, one cycle after capture.
- Latency: avg_valid pulses 1 cycle after the sar_valid cycle of the completing sample. last_raw updates on the cycle after sar_valid.
- enable=0 in any state other than IDLE:
  - Abort to IDLE next cycle with sar_go=0.
  - Clear accumulator and count. avg_out, last_raw and timeout_err hold.
  - Any sar_valid arriving in the same cycle is ignored.
- timeout_err is sticky until clear_err=1. If clear_err and a new timeout occur in the same cycle, set wins.
- busy equals sar_go.
- sar_valid seen in IDLE, START or WAIT is ignored.

Optional Feature:
- Macro: SAR_SEQ_AVG_ROUND_EN.
- Defined: avg_out = (accumulator + 2^(AVG_LOG2-1)) >> AVG_LOG2, round-half-up. The addition is computed at 9+AVG_LOG2 bits and the result saturates at 255. No effect when AVG_LOG2=0.
- Undefined: truncating shift as above.

Test Plan:
- Bench setup: SAMPLE_PERIOD=50, AVG_LOG2=2, TIMEOUT=40, and a behavioural converter model that asserts valid 20 cycles after go rises.
- Single-sample timing: AVG_LOG2=0, result 0x5A → sar_go high 21 cycles; last_raw=0x5A and avg_out=0x5A with avg_valid pulsing 1 cycle after valid; next sar_go rise exactly 50 cycles after the first.
- Averaging: results 10,11,12,14 → one avg_valid after the 4th capture with avg_out=11 (12 with SAR_SEQ_AVG_ROUND_EN). Results 255×4 → avg_out=255 in both builds.
- Timeout: model never asserts valid → sar_go drops after 40 cycles and timeout_err=1. Next four good samples of 0x80 → avg_out=0x80, the timed-out sample is excluded. clear_err pulse → timeout_err=0.
- Overrun: valid delayed 60 cycles (TIMEOUT raised to 100) → next sar_go rises exactly 2 cycles after it falls, with no error flagged.
- Abort: enable dropped mid-CONV after 2 captures → sar_go=0 next cycle. Re-enable and feed 4×0x40 → avg_out=0x40, with no contamination from the earlier partial samples.
- Reset mid-conversion: assert reset asynchronously while sar_go=1 → sar_go, avg_valid and busy go 0 immediately, and all outputs read 0.
